// File: rtl/obi_sram_slave_if.sv
// OBI slave port bundle for the SRAM model.
// Master drives requests; slave returns grant and responses.
interface obi_sram_slave_if;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic [2:0]  outstanding_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, outstanding_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, outstanding_o
   );
endinterface

// File: rtl/obi_sram_slave.sv
// Word-organised SRAM with an OBI slave port.
// Fixed response latency, outstanding cap, periodic grant stall.
module obi_sram_slave #(
   parameter int ADDR_WIDTH       = 13,
   parameter int RESP_LAT         = 1,
   parameter int MAX_OUTSTANDING  = 2,
   parameter int GNT_STALL_PERIOD = 0
) (
   input logic             clk_i,
   input logic             rst_ni,
   obi_sram_slave_if.slave bus
);
   localparam int WORDS    = 2 ** (ADDR_WIDTH - 2);
   localparam int IW       = ADDR_WIDTH - 2;
   localparam bit STALL_EN = GNT_STALL_PERIOD >= 2;
   localparam int CW       = (GNT_STALL_PERIOD > 2) ?
                             $clog2(GNT_STALL_PERIOD) : 1;
   localparam logic [CW-1:0] STALL_AT = CW'(GNT_STALL_PERIOD - 1);
   localparam logic [2:0]    MAX_OUT  = 3'(MAX_OUTSTANDING);

   logic [31:0]              r_mem [WORDS];
   logic [CW-1:0]            r_stall_cnt;
   logic [RESP_LAT-1:0]      r_pv;
   logic [RESP_LAT-1:0][31:0] r_pd;
   logic [2:0]               r_outst;

   logic [IW-1:0] w_idx;
   logic          w_stall;
   logic          w_rvalid;
   logic          w_gnt;
   logic          w_acc;
   logic [31:0]   w_rsp;
   logic          w_unused;

   assign w_idx    = bus.addr_i[ADDR_WIDTH-1:2];
   assign w_unused = ^{bus.addr_i[31:ADDR_WIDTH], bus.addr_i[1:0]};
   assign w_stall  = STALL_EN && (r_stall_cnt == STALL_AT);
   assign w_rvalid = r_pv[RESP_LAT-1];
   assign w_gnt    = rst_ni && bus.req_i && !w_stall &&
                     ((r_outst < MAX_OUT) || w_rvalid);
   assign w_acc    = bus.req_i && w_gnt;
   assign w_rsp    = (w_acc && !bus.we_i) ? r_mem[w_idx] : 32'h0;

   assign bus.gnt_o         = w_gnt;
   assign bus.rvalid_o      = w_rvalid;
   assign bus.rdata_o       = r_pd[RESP_LAT-1];
   assign bus.outstanding_o = r_outst;

   // Free-running stall phase counter, wraps at the stall slot
   always_ff @(posedge clk_i) begin
      if (!rst_ni || !STALL_EN || (r_stall_cnt == STALL_AT))
         r_stall_cnt <= '0;
      else
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   // Response shift pipeline and in-flight transaction count
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pv    <= '0;
         r_pd    <= '0;
         r_outst <= '0;
      end else begin
         r_pv[0] <= w_acc;
         r_pd[0] <= w_rsp;
         for (int i = 1; i < RESP_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
         end
         r_outst <= r_outst + {2'b00, w_acc} - {2'b00, w_rvalid};
      end
   end

   // Byte-lane writes; storage survives reset
   always_ff @(posedge clk_i) begin
      if (w_acc && bus.we_i) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.be_i[k])
               r_mem[w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
         end
      end
   end

`ifndef SYNTHESIS
   // Configuration sanity and count bookkeeping checks
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (RESP_LAT >= 1 && RESP_LAT <= 4);
         assert (MAX_OUTSTANDING >= 1 &&
                 MAX_OUTSTANDING <= RESP_LAT + 1);
         assert (GNT_STALL_PERIOD != 1);
         assert (r_outst <= MAX_OUT);
         assert (!(w_rvalid && (r_outst == 3'd0)));
      end
   end
`endif
endmodule

// File: tb/tb_obi_sram_slave.sv
// Bench for obi_sram_slave: three configurations against a
// queue-based reference model plus directed scenarios.
module tb_obi_sram_slave;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit armed = 1'b0;
   longint now = 0;

   int P_LAT [3] = '{1, 3, 1};
   int P_MAX [3] = '{2, 2, 2};
   int P_PER [3] = '{0, 0, 4};

   logic        req_d   [3];
   logic        we_d    [3];
   logic [31:0] addr_d  [3];
   logic [3:0]  be_d    [3];
   logic [31:0] wdata_d [3];
   logic        gnt_s   [3];
   logic        rv_s    [3];
   logic [31:0] rd_s    [3];
   logic [2:0]  os_s    [3];

   obi_sram_slave_if b0 ();
   obi_sram_slave_if b1 ();
   obi_sram_slave_if b2 ();

   assign b0.req_i = req_d[0];
   assign b0.we_i = we_d[0];
   assign b0.addr_i = addr_d[0];
   assign b0.be_i = be_d[0];
   assign b0.wdata_i = wdata_d[0];
   assign gnt_s[0] = b0.gnt_o;
   assign rv_s[0] = b0.rvalid_o;
   assign rd_s[0] = b0.rdata_o;
   assign os_s[0] = b0.outstanding_o;

   assign b1.req_i = req_d[1];
   assign b1.we_i = we_d[1];
   assign b1.addr_i = addr_d[1];
   assign b1.be_i = be_d[1];
   assign b1.wdata_i = wdata_d[1];
   assign gnt_s[1] = b1.gnt_o;
   assign rv_s[1] = b1.rvalid_o;
   assign rd_s[1] = b1.rdata_o;
   assign os_s[1] = b1.outstanding_o;

   assign b2.req_i = req_d[2];
   assign b2.we_i = we_d[2];
   assign b2.addr_i = addr_d[2];
   assign b2.be_i = be_d[2];
   assign b2.wdata_i = wdata_d[2];
   assign gnt_s[2] = b2.gnt_o;
   assign rv_s[2] = b2.rvalid_o;
   assign rd_s[2] = b2.rdata_o;
   assign os_s[2] = b2.outstanding_o;

   obi_sram_slave u0 (
      .clk_i (clk), .rst_ni (rst_n), .bus (b0.slave));

   obi_sram_slave #(
      .RESP_LAT (3), .MAX_OUTSTANDING (2)
   ) u1 (
      .clk_i (clk), .rst_ni (rst_n), .bus (b1.slave));

   obi_sram_slave #(
      .GNT_STALL_PERIOD (4)
   ) u2 (
      .clk_i (clk), .rst_ni (rst_n), .bus (b2.slave));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   // reference model: word array plus in-order response queue
   logic [31:0] m_mem [3][2048];
   longint      q_due [3][8];
   logic [31:0] q_dat [3][8];
   int          q_h [3];
   int          q_n [3];
   int          stc [3];
   int          g_cnt [3];
   int          r_cnt [3];
   logic [31:0] fill_dat [3][32];

   task automatic model_step(input int i);
      bit          erv, stall, eg;
      logic [31:0] erd;
      int          w, s;
      erv = (q_n[i] > 0) && (q_due[i][q_h[i]] == now);
      erd = erv ? q_dat[i][q_h[i]] : 32'h0;
      stall = (P_PER[i] >= 2) && ((stc[i] % P_PER[i]) == P_PER[i] - 1);
      eg = rst_n && req_d[i] && !stall && (q_n[i] < P_MAX[i] || erv);
      chk($sformatf("u%0d_gnt@%0d", i, now), 32'(gnt_s[i]), 32'(eg));
      chk($sformatf("u%0d_rvalid@%0d", i, now), 32'(rv_s[i]), 32'(erv));
      chk($sformatf("u%0d_rdata@%0d", i, now), rd_s[i], erd);
      chk($sformatf("u%0d_outst@%0d", i, now), 32'(os_s[i]), 32'(q_n[i]));
      if (!rst_n) begin
         q_n[i] = 0;
         q_h[i] = 0;
         stc[i] = 0;
         g_cnt[i] = 0;
         r_cnt[i] = 0;
      end else begin
         if (rv_s[i]) r_cnt[i]++;
         if (gnt_s[i] && req_d[i]) g_cnt[i]++;
         if (erv) begin
            q_h[i] = (q_h[i] + 1) % 8;
            q_n[i]--;
         end
         if (eg) begin
            w = int'(addr_d[i][12:2]);
            s = (q_h[i] + q_n[i]) % 8;
            q_due[i][s] = now + P_LAT[i];
            q_dat[i][s] = we_d[i] ? 32'h0 : m_mem[i][w];
            q_n[i]++;
            if (we_d[i])
               for (int b = 0; b < 4; b++)
                  if (be_d[i][b])
                     m_mem[i][w][8*b +: 8] = wdata_d[i][8*b +: 8];
         end
         stc[i]++;
      end
   endtask

   always @(negedge clk) begin
      if (armed)
         for (int i = 0; i < 3; i++) model_step(i);
      now++;
   end

   task automatic op(input int i, input bit we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd,
                     input bit hold);
      int n;
      req_d[i] = 1'b1;
      we_d[i] = we;
      addr_d[i] = a;
      be_d[i] = be;
      wdata_d[i] = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!gnt_s[i] && n < 40);
      if (!gnt_s[i])
         chk($sformatf("u%0d_gnt_wait", i), 32'(gnt_s[i]), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) req_d[i] = 1'b0;
   endtask

   task automatic rd_expect(input int i, input logic [31:0] a,
                            input logic [31:0] want, input string tag);
      op(i, 1'b0, a, 4'hF, 32'h0, 1'b0);
      repeat (P_LAT[i]) @(negedge clk);
      chk({tag, "_rv"}, 32'(rv_s[i]), 32'd1);
      chk({tag, "_data"}, rd_s[i], want);
   endtask

   task automatic rand_run(input int i, input int n);
      logic [31:0] a;
      bit          hold;
      for (int k = 0; k < n; k++) begin
         a = $urandom;
         a[12:7] = 6'h0;
         hold = 1'($urandom_range(0, 1));
         op(i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
            $urandom, hold);
         if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      req_d[i] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0]  pat;
      logic [31:0] d;
      bit          g;
      int          k, lows, last;
      for (int i = 0; i < 3; i++) begin
         req_d[i] = 1'b0;
         we_d[i] = 1'b0;
         addr_d[i] = 32'h0;
         be_d[i] = 4'h0;
         wdata_d[i] = 32'h0;
         q_h[i] = 0;
         q_n[i] = 0;
         stc[i] = 0;
         g_cnt[i] = 0;
         r_cnt[i] = 0;
      end
      repeat (2) @(posedge clk);
      armed = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < 32; w++) begin
            d = $urandom;
            fill_dat[i][w] = d;
            op(i, 1'b1, 32'(w * 4), 4'hF, d, 1'b1);
         end
         req_d[i] = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end

      op(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
      rd_expect(0, 32'h10, 32'hDEADBEEF, "wr_rd_b2b");
      repeat (3) @(posedge clk);
      #1;
      op(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1);
      op(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b1);
      rd_expect(0, 32'h20, 32'h11BB33DD, "byte_en");
      repeat (3) @(posedge clk);
      #1;
      op(0, 1'b1, 32'h0000_2004, 4'hF, 32'hCAFEF00D, 1'b1);
      rd_expect(0, 32'h4, 32'hCAFEF00D, "alias");
      repeat (4) @(posedge clk);
      #1;

      req_d[1] = 1'b1;
      we_d[1] = 1'b0;
      be_d[1] = 4'hF;
      addr_d[1] = 32'h0;
      k = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         pat[c] = gnt_s[1];
         g = gnt_s[1];
         @(posedge clk);
         #1;
         if (g) begin
            k++;
            addr_d[1] = 32'(k * 4);
            if (k == 4) req_d[1] = 1'b0;
         end
      end
      chk("lat3_gnt_pattern", 32'(pat), 32'b11011);
      repeat (6) @(posedge clk);
      #1;

      req_d[2] = 1'b1;
      we_d[2] = 1'b0;
      be_d[2] = 4'hF;
      addr_d[2] = 32'h8;
      lows = 0;
      last = -1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (!gnt_s[2]) begin
            lows++;
            if (last >= 0) chk("stall_gap", 32'(c - last), 32'd4);
            last = c;
         end
      end
      chk("stall_lows", 32'(lows), 32'd3);
      @(posedge clk);
      #1 req_d[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      op(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rst_no_rvalid", 32'(rv_s[1]), 32'd0);
         chk("rst_outst", 32'(os_s[1]), 32'd0);
      end
      @(posedge clk);
      #1;
      rd_expect(1, 32'h40, fill_dat[1][16], "post_rst_read");
      repeat (4) @(posedge clk);
      #1;

      fork
         rand_run(0, 300);
         rand_run(1, 300);
         rand_run(2, 300);
      join

      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("u%0d_resp_count", i), 32'(r_cnt[i]), 32'(g_cnt[i]));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/obi_sram_slave.md
Name: obi_sram_slave

Overview:
- Word-organised SRAM model with an OBI slave port.
- Instantiated as the instruction memory and the data memory in the lint/simulation top of the cv32e40p core.
- Sized from the core config package: INSTR_ADDR_MEM_WIDTH for the instruction instance, DATA_ADDR_MEM_WIDTH for the data instance.
- Consumes the core's OBI requests and produces grant/rvalid responses with a configurable fixed latency and a configurable grant-stall pattern.

Parameters:
ADDR_WIDTH, 13, byte-address bits decoded; memory is 2^ADDR_WIDTH bytes = 2^(ADDR_WIDTH-2) 32-bit words
RESP_LAT, 1, cycles from the grant edge to rvalid_o; legal range 1..4
MAX_OUTSTANDING, 2, granted-but-unresponded transaction cap; legal range 1..RESP_LAT+1
GNT_STALL_PERIOD, 0, 0 = never stall; N>=2 = gnt_o withheld one cycle in every N

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
req_i  input  1  OBI request
gnt_o  output  1  OBI grant (combinational)
addr_i  input  32  byte address
we_i  input  1  1 = write, 0 = read
be_i  input  4  byte enables
wdata_i  input  32  write data
rvalid_o  output  1  response valid, one cycle per transaction
rdata_o  output  32  read data; 0 for write responses
outstanding_o  output  3  current outstanding count, for bench checking

Behaviour:
- Reset is sampled on the clk_i rising edge, rst_ni=0.
  - Cleared: stall counter, response pipeline, outstanding count.
  - After reset: rvalid_o=0, rdata_o=0, outstanding_o=0.
  - gnt_o=0 while rst_ni=0.
  - Memory contents are not reset.
- Word index = addr_i[ADDR_WIDTH-1:2].
  - addr_i[1:0] ignored.
  - Bits above ADDR_WIDTH-1 ignored, so addresses alias with wrap-around. Example: 0x0000_2000 aliases 0x0 when ADDR_WIDTH=13.
- Stall counter:
  - Free-running modulo GNT_STALL_PERIOD, incremented every cycle out of reset.
  - stall = (GNT_STALL_PERIOD>=2) && (counter == GNT_STALL_PERIOD-1).
- gnt_o = rst_ni && req_i && !stall && (outstanding < MAX_OUTSTANDING || rvalid_o).
  - A response retiring in the same cycle frees a slot.
- Transaction accepted on a clock edge where req_i && gnt_o:
  - Read: the addressed word is captured at that edge into pipeline stage 0.
  - Write: bytes with be_i[k]=1 are updated with wdata_i[8k+7:8k] at that edge. Captured response data is 0.
  - be_i=0 write: no memory change, response still issued.
  - Read and write to the same word are never simultaneous (single port). Back-to-back write then read of the same word returns the new data.
- Response pipeline:
  - RESP_LAT stages of {valid, data}, shifting every cycle with no backpressure.
  - rvalid_o/rdata_o are driven from the last stage.
  - Accepted at edge t means rvalid_o=1 during cycle t+RESP_LAT.
  - With RESP_LAT=1, rvalid appears the cycle after the grant.
  - Responses are in order, exactly one per grant.
- When rvalid_o=0, rdata_o holds 0.
- outstanding_o:
  - +1 on accept, -1 on rvalid_o; both in one cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - Never decrements below 0. A response with count 0 is unreachable; flag it with an assertion.
- Request held without grant: address, data and attributes may change, since OBI requires stability only after grant in this model. The block samples only at the accept edge.
- Reset mid-operation: in-flight responses are discarded, with no rvalid after reset release. Writes already accepted persist.
- Assertions, simulation only:
  - RESP_LAT within 1..4.
  - MAX_OUTSTANDING within 1..RESP_LAT+1.
  - GNT_STALL_PERIOD is not 1.
  - outstanding_o never exceeds MAX_OUTSTANDING.

Test Plan:
- Defaults; write addr 0x10, be=4'hF, wdata=0xDEADBEEF at cycle 5; read 0x10 at cycle 6 -> gnt in both cycles, rvalid at cycles 6 and 7, rdata=0 then 0xDEADBEEF.
- Write 0x20 with 0x11223344, then write 0x20 with be=4'b0101, wdata=0xAABBCCDD, then read 0x20 -> rdata=0x11BB33DD.
- ADDR_WIDTH=13; write 0x0000_2004 with 0xCAFEF00D, read 0x4 -> 0xCAFEF00D (alias).
- RESP_LAT=3, MAX_OUTSTANDING=2, req_i held high reading 4 words -> gnt pattern 1,1,0,1,1; each rvalid exactly 3 cycles after its grant; outstanding_o never exceeds 2; data in order.
- GNT_STALL_PERIOD=4, req_i constantly high -> gnt_o low exactly every 4th cycle; number of rvalid pulses equals number of grants.
- Read granted, rst_ni=0 the following cycle for 2 cycles -> rvalid_o, rdata_o, outstanding_o all 0 during and after reset, no stray rvalid; previously written data is still readable after reset.
